// File: rtl/data_buffer_pkg.sv
// Shared definitions for the 64-byte USB <-> AHB-Lite data buffer.
// Holds the capacity and width constants, the transfer-size encoding
// and a helper that turns a transfer size into a byte count.
package data_buffer_pkg;

  localparam int DEPTH = 64;
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {SZ_1B, SZ_2B, SZ_3B, SZ_4B} xfer_size_t;

  typedef logic [7:0] byte_t;

  // Number of bytes moved by one AHB transfer of the given size (1..4).
  function automatic logic [2:0] size_bytes(input xfer_size_t sz);
    return {1'b0, sz} + 3'd1;
  endfunction

endpackage

// File: rtl/data_buffer_mem.sv
// Byte-wide circular storage for data_buffer.
// Up to four byte writes and four byte reads per cycle, each group at
// consecutive addresses starting from a base that wraps modulo DEPTH.
// Ports:
//   clk      in   clock; writes take effect on the rising edge
//   we_i     in   per-lane write enable, lane k writes address waddr_i+k
//   waddr_i  in   write base address
//   wdata_i  in   write data, lane k in [8k+7:8k]
//   raddr_i  in   read base address
//   rdata_o  out  combinational read data, lane k from address raddr_i+k
module data_buffer_mem
  import data_buffer_pkg::*;
(
  input  logic             clk,
  input  logic [3:0]       we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [31:0]      wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [31:0]      rdata_o
);

  byte_t mem_q [DEPTH];

  // Contents are never reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (we_i[k]) mem_q[waddr_i + PTR_W'(k)] <= wdata_i[8*k +: 8];
    end
  end

  // The address sum is PTR_W bits wide, so it wraps 63 -> 0 by itself.
  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < 4; k++) begin
      rdata_o[8*k +: 8] = mem_q[raddr_i + PTR_W'(k)];
    end
  end

endmodule

// File: rtl/data_buffer.sv
// 64-byte byte-wide FIFO shared between the USB packet engines and the
// AHB-Lite slave. RX bytes are pushed singly and popped 1-4 at a time by
// AHB reads; TX bytes are pushed 1-4 at a time by AHB writes and popped
// singly by the USB TX side. Occupancy is reported for flow control.
// Ports:
//   clk                   in   system clock
//   n_rst                 in   synchronous reset, active high
//   clear                 in   synchronous flush, same effect as reset
//   store_rx_packet_data  in   push rx_packet_data (ignored when reserved)
//   rx_packet_data        in   byte from USB RX
//   get_rx_data           in   pop data_size+1 bytes into rx_data
//   data_size             in   AHB transfer size, 0..3 -> 1..4 bytes
//   tx_data               in   AHB write data, byte 0 in [7:0]
//   store_tx_data         in   push data_size+1 bytes of tx_data
//   get_tx_packet_data    in   pop one byte into tx_packet_data
//   buffer_reserved       in   buffer claimed for a TX transfer
//   buffer_occupancy      out  bytes stored, 0..64
//   rx_data               out  registered AHB read data
//   tx_packet_data        out  registered byte for USB TX
module data_buffer
  import data_buffer_pkg::*;
(
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             store_rx_packet_data,
  input  logic [7:0]       rx_packet_data,
  input  logic             get_rx_data,
  input  logic [1:0]       data_size,
  input  logic [31:0]      tx_data,
  input  logic             store_tx_data,
  input  logic             get_tx_packet_data,
  input  logic             buffer_reserved,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic [31:0]      rx_data,
  output logic [7:0]       tx_packet_data
);

  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [31:0]      rx_data_q;
  byte_t            tx_byte_q;

  logic [2:0]       wr_req, rd_req, wr_acc, rd_act;
  logic [OCC_W-1:0] free_space;
  logic [3:0]       we;
  logic [31:0]      wdata, rdata, rd_masked;
  logic             flush;

  assign flush = n_rst | clear;

  always_comb begin
    wr_req = 3'd0;
    if (store_tx_data)                                wr_req = size_bytes(xfer_size_t'(data_size));
    else if (store_rx_packet_data && !buffer_reserved) wr_req = 3'd1;

    rd_req = 3'd0;
    if (get_rx_data)             rd_req = size_bytes(xfer_size_t'(data_size));
    else if (get_tx_packet_data) rd_req = 3'd1;

    // Space and availability both come from the pre-edge occupancy, so a
    // same-cycle pop never makes room for a same-cycle push and vice versa.
    free_space = OCC_W'(DEPTH) - occ_q;
    wr_acc = ({{(OCC_W-3){1'b0}}, wr_req} > free_space) ? free_space[2:0] : wr_req;
    rd_act = ({{(OCC_W-3){1'b0}}, rd_req} > occ_q)      ? occ_q[2:0]      : rd_req;
    if (flush) begin
      wr_acc = 3'd0;
      rd_act = 3'd0;
    end

    wdata = store_tx_data ? tx_data : {24'h0, rx_packet_data};

    we        = '0;
    rd_masked = '0;
    for (int k = 0; k < 4; k++) begin
      we[k] = (3'(k) < wr_acc);
      if (3'(k) < rd_act) rd_masked[8*k +: 8] = rdata[8*k +: 8];
    end

    wptr_d = wptr_q + PTR_W'(wr_acc);
    rptr_d = rptr_q + PTR_W'(rd_act);
    occ_d  = occ_q + OCC_W'(wr_acc) - OCC_W'(rd_act);
  end

  data_buffer_mem u_mem (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wptr_q),
    .wdata_i (wdata),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (flush) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      occ_q     <= '0;
      rx_data_q <= '0;
      tx_byte_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      occ_q  <= occ_d;
      // An AHB read takes priority; the TX byte then keeps its old value.
      if (get_rx_data)             rx_data_q <= rd_masked;
      else if (get_tx_packet_data) tx_byte_q <= rd_masked[7:0];
    end
  end

  assign buffer_occupancy = occ_q;
  assign rx_data          = rx_data_q;
  assign tx_packet_data   = tx_byte_q;

endmodule

// File: tb/tb_data_buffer.sv
// Self-checking bench for data_buffer, with a queue-based reference model.
module tb_data_buffer;

  logic        clk = 1'b0;
  logic        n_rst, clear, store_rx_packet_data, get_rx_data;
  logic        store_tx_data, get_tx_packet_data, buffer_reserved;
  logic [7:0]  rx_packet_data;
  logic [1:0]  data_size;
  logic [31:0] tx_data;
  logic [6:0]  buffer_occupancy;
  logic [31:0] rx_data;
  logic [7:0]  tx_packet_data;

  int errors = 0;
  int checks = 0;

  logic [7:0]  q[$];
  logic [31:0] exp_rx;
  logic [7:0]  exp_tx;

  data_buffer dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_rx_data          (get_rx_data),
    .data_size            (data_size),
    .tx_data              (tx_data),
    .store_tx_data        (store_tx_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .buffer_reserved      (buffer_reserved),
    .buffer_occupancy     (buffer_occupancy),
    .rx_data              (rx_data),
    .tx_packet_data       (tx_packet_data)
  );

  always #5 clk = ~clk;

  task automatic idle();
    n_rst = 0; clear = 0; store_rx_packet_data = 0; get_rx_data = 0;
    store_tx_data = 0; get_tx_packet_data = 0; buffer_reserved = 0;
    rx_packet_data = 0; data_size = 0; tx_data = 0;
  endtask

  // Reference: FIFO of bytes; pops and free space judged on pre-edge content.
  task automatic model_edge();
    int old_n, nrd, free;
    logic [31:0] w;
    if (n_rst || clear) begin
      q.delete(); exp_rx = 0; exp_tx = 0;
      return;
    end
    old_n = q.size();
    free  = 64 - old_n;
    if (get_rx_data) begin
      nrd = int'(data_size) + 1;
      w = 0;
      for (int k = 0; k < nrd; k++) if (q.size() > 0) w[8*k +: 8] = q.pop_front();
      exp_rx = w;
    end else if (get_tx_packet_data) begin
      exp_tx = (q.size() > 0) ? q.pop_front() : 8'h00;
    end
    if (store_tx_data) begin
      for (int k = 0; k <= int'(data_size); k++)
        if (free > 0) begin q.push_back(tx_data[8*k +: 8]); free--; end
    end else if (store_rx_packet_data && !buffer_reserved && free > 0) begin
      q.push_back(rx_packet_data);
    end
  endtask

  // Inputs are already driven; update the model, clock, sample 1 ns later.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push_rx(input logic [7:0] b);
    store_rx_packet_data = 1; rx_packet_data = b; tick();
  endtask

  task automatic read_rx(input logic [1:0] sz);
    get_rx_data = 1; data_size = sz; tick();
  endtask

  task automatic write_tx(input logic [1:0] sz, input logic [31:0] d, input logic rsv);
    store_tx_data = 1; data_size = sz; tx_data = d; buffer_reserved = rsv; tick();
  endtask

  task automatic pop_tx();
    get_tx_packet_data = 1; tick();
  endtask

  task automatic test_reset();
    n_rst = 1; tick();
    if (buffer_occupancy !== 7'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", buffer_occupancy); end
    checks++;
    if (rx_data !== 32'h0) begin errors++; $display("FAIL reset_rx got=%h exp=0", rx_data); end
    checks++;
    if (tx_packet_data !== 8'h0) begin errors++; $display("FAIL reset_tx got=%h exp=0", tx_packet_data); end
    checks++;
  endtask

  task automatic test_rx_path();
    n_rst = 1; tick();
    push_rx(8'hA1); push_rx(8'hB2); push_rx(8'hC3); push_rx(8'hD4);
    if (buffer_occupancy !== 7'd4) begin errors++; $display("FAIL rx_occ4 got=%0d exp=4", buffer_occupancy); end
    checks++;
    read_rx(2'd1);
    if (rx_data !== 32'h0000B2A1) begin errors++; $display("FAIL rx_read2 got=%h exp=0000b2a1", rx_data); end
    checks++;
    read_rx(2'd0);
    if (rx_data !== 32'h000000C3) begin errors++; $display("FAIL rx_read_c3 got=%h exp=000000c3", rx_data); end
    checks++;
    read_rx(2'd0);
    if (rx_data !== 32'h000000D4) begin errors++; $display("FAIL rx_read_d4 got=%h exp=000000d4", rx_data); end
    checks++;
    if (buffer_occupancy !== 7'd0) begin errors++; $display("FAIL rx_occ0 got=%0d exp=0", buffer_occupancy); end
    checks++;
  endtask

  task automatic test_tx_path();
    n_rst = 1; tick();
    // RX push alongside a reserved AHB write: the write wins, RX is also blocked.
    store_rx_packet_data = 1; rx_packet_data = 8'hEE;
    write_tx(2'd3, 32'h44332211, 1'b1);
    if (buffer_occupancy !== 7'd4) begin errors++; $display("FAIL tx_occ4 got=%0d exp=4", buffer_occupancy); end
    checks++;
    buffer_reserved = 1; store_rx_packet_data = 1; rx_packet_data = 8'h77; tick();
    if (buffer_occupancy !== 7'd4) begin errors++; $display("FAIL tx_reserved_block got=%0d exp=4", buffer_occupancy); end
    checks++;
    pop_tx();
    if (tx_packet_data !== 8'h11) begin errors++; $display("FAIL tx_pop1 got=%h exp=11", tx_packet_data); end
    checks++;
    pop_tx();
    if (tx_packet_data !== 8'h22) begin errors++; $display("FAIL tx_pop2 got=%h exp=22", tx_packet_data); end
    checks++;
    if (buffer_occupancy !== 7'd2) begin errors++; $display("FAIL tx_occ2 got=%0d exp=2", buffer_occupancy); end
    checks++;
  endtask

  task automatic test_random_rx_words();
    n_rst = 1; tick();
    for (int i = 0; i < 32; i++) push_rx(8'($urandom));
    for (int i = 0; i < 8; i++) begin
      read_rx(2'd3);
      if (rx_data !== exp_rx) begin errors++; $display("FAIL rand_word%0d got=%h exp=%h", i, rx_data, exp_rx); end
      checks++;
    end
    if (buffer_occupancy !== 7'd0) begin errors++; $display("FAIL rand_occ0 got=%0d exp=0", buffer_occupancy); end
    checks++;
  endtask

  // Starts with pointers at 32 from the previous test, so the fill wraps.
  task automatic test_full_wrap();
    for (int i = 0; i < 16; i++) write_tx(2'd3, $urandom, 1'b0);
    if (buffer_occupancy !== 7'd64) begin errors++; $display("FAIL full_occ64 got=%0d exp=64", buffer_occupancy); end
    checks++;
    write_tx(2'd3, 32'hDEADBEEF, 1'b0);
    if (buffer_occupancy !== 7'd64) begin errors++; $display("FAIL full_drop got=%0d exp=64", buffer_occupancy); end
    checks++;
    for (int i = 0; i < 64; i++) begin
      pop_tx();
      if (tx_packet_data !== exp_tx) begin errors++; $display("FAIL full_pop%0d got=%h exp=%h", i, tx_packet_data, exp_tx); end
      checks++;
    end
    if (buffer_occupancy !== 7'd0) begin errors++; $display("FAIL full_drain got=%0d exp=0", buffer_occupancy); end
    checks++;
  endtask

  task automatic test_underflow();
    logic [7:0] b;
    b = 8'($urandom_range(1, 255));
    push_rx(b);
    read_rx(2'd3);
    if (rx_data !== {24'h0, b}) begin errors++; $display("FAIL under_rx got=%h exp=%h", rx_data, {24'h0, b}); end
    checks++;
    if (buffer_occupancy !== 7'd0) begin errors++; $display("FAIL under_occ got=%0d exp=0", buffer_occupancy); end
    checks++;
    push_rx(8'h5C); pop_tx();
    pop_tx();
    if (tx_packet_data !== 8'h00) begin errors++; $display("FAIL under_tx got=%h exp=00", tx_packet_data); end
    checks++;
  endtask

  task automatic test_midstream_flush();
    for (int pass = 0; pass < 2; pass++) begin
      push_rx(8'h12); push_rx(8'h34); push_rx(8'h56);
      read_rx(2'd0); pop_tx();
      if (pass == 0) n_rst = 1; else clear = 1;
      store_rx_packet_data = 1; rx_packet_data = 8'h99; get_rx_data = 1;
      tick();
      if (buffer_occupancy !== 7'd0) begin errors++; $display("FAIL flush%0d_occ got=%0d exp=0", pass, buffer_occupancy); end
      checks++;
      if (rx_data !== 32'h0) begin errors++; $display("FAIL flush%0d_rx got=%h exp=0", pass, rx_data); end
      checks++;
      if (tx_packet_data !== 8'h0) begin errors++; $display("FAIL flush%0d_tx got=%h exp=0", pass, tx_packet_data); end
      checks++;
      write_tx(2'd1, 32'h0000BBAA, 1'b0);
      read_rx(2'd3);
      if (rx_data !== 32'h0000BBAA) begin errors++; $display("FAIL flush%0d_restart got=%h exp=0000bbaa", pass, rx_data); end
      checks++;
    end
  endtask

  task automatic test_back_to_back();
    n_rst = 1; tick();
    for (int i = 0; i < 300; i++) begin
      clear                = ($urandom_range(0, 63) == 0);
      store_rx_packet_data = $urandom_range(0, 1);
      rx_packet_data       = 8'($urandom);
      store_tx_data        = ($urandom_range(0, 2) == 0);
      tx_data              = $urandom;
      data_size            = 2'($urandom);
      buffer_reserved      = ($urandom_range(0, 3) == 0);
      get_rx_data          = ($urandom_range(0, 3) == 0);
      get_tx_packet_data   = $urandom_range(0, 1);
      tick();
      if (buffer_occupancy !== 7'(q.size())) begin errors++; $display("FAIL b2b%0d_occ got=%0d exp=%0d", i, buffer_occupancy, q.size()); end
      checks++;
      if (rx_data !== exp_rx) begin errors++; $display("FAIL b2b%0d_rx got=%h exp=%h", i, rx_data, exp_rx); end
      checks++;
      if (tx_packet_data !== exp_tx) begin errors++; $display("FAIL b2b%0d_tx got=%h exp=%h", i, tx_packet_data, exp_tx); end
      checks++;
    end
  endtask

  initial begin
    idle();
    exp_rx = 0; exp_tx = 0;
    @(posedge clk); #1;
    test_reset();
    test_rx_path();
    test_tx_path();
    test_random_rx_words();
    test_full_wrap();
    test_underflow();
    test_midstream_flush();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
